mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch port and the load/store data port of the RV32IMAFB core.
- Sits between the fetch unit / memory-access stage and the BRAM, upstream of the byte-lane memory controller.
- Grants one request per cycle and returns read data one cycle later to the requester that owns the slot.
- Holds the port for atomic read-modify-write sequences (A extension) and prevents fetch starvation.

Parameters:
- ADDR_W, 32, address width of both requester ports and the memory port.
- MAX_WAIT, 4, consecutive denied fetch cycles after which fetch wins the next arbitration; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch accepted this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  32  fetch data
- d_req_i  in  1  data request
- d_we_i  in  1  data write
- d_be_i  in  4  write byte enables
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  32  write data
- d_lock_i  in  1  keep the port after this access (AMO/LR read phase)
- d_gnt_o  out  1  data accepted this cycle
- d_rvalid_o  out  1  data response valid (loads and stores)
- d_rdata_o  out  32  load data
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  4  per-byte write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid the cycle after mem_en_o

Behaviour:
- Reset is asynchronous. It sets state to ARB, the wait counter to 0, the owner register to NONE, and the lock flag to 0. The registered outputs if_rvalid_o and d_rvalid_o are 0.
- Grant is combinational in the request cycle. At most one of if_gnt_o / d_gnt_o is high.
- mem_en_o = if_gnt_o | d_gnt_o.
- mem_addr_o, mem_we_o and mem_wdata_o come from the granted port.
- mem_we_o = d_be_i when the data port is granted with d_we_i = 1; otherwise 4'b0.
- With no grant, all mem_* outputs are 0.
- Response latency is exactly 1 cycle. The owner register captures the granted port.
  - The next cycle, the owner's rvalid pulses high for one cycle.
  - Its rdata is mem_rdata_i.
  - The non-owner's rdata is 0.
- Stores also produce d_rvalid_o; d_rdata_o is don't-care for stores.
- FSM states:
  - ARB:
    - If only one port requests, that port is granted.
    - If both request, data wins, unless wait_cnt == MAX_WAIT, in which case fetch wins.
    - On a data grant with d_lock_i = 1, go to LOCKED.
  - LOCKED:
    - Only the data port can be granted. if_gnt_o = 0 regardless of wait_cnt.
    - On a data grant with d_lock_i = 0, return to ARB. This is the write phase of the AMO.
    - On a data grant with d_lock_i = 1, stay in LOCKED.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on cycles where if_req_i = 1 and if_gnt_o = 0.
  - Clears on if_gnt_o, or when if_req_i = 0.
- Requesters hold req/addr/data stable until they see gnt; the block does not latch unaccepted requests.
- Reset asserted mid-access drops any pending rvalid. Reset mid-lock returns to ARB.
- Back-to-back grants every cycle are legal: throughput is 1 access/cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: in ARB with both ports requesting, the port not granted last time wins. A one-bit last-granted register resets to "fetch", so data wins the first tie. wait_cnt logic is removed, and MAX_WAIT is ignored. LOCKED behaviour is unchanged.
- Undefined: fixed data priority with the MAX_WAIT starvation guard, as in Behaviour.

Test Plan:
- Single fetch: if_req_i = 1, if_addr_i = 0x100, RAM[0x100] = 0x00000013 → if_gnt_o = 1 and mem_addr_o = 0x100 in the same cycle; next cycle if_rvalid_o = 1, if_rdata_o = 0x00000013, d_rvalid_o = 0.
- Collision: both ports request every cycle, MAX_WAIT = 4, fetch held → d_gnt_o for 4 cycles, then if_gnt_o in cycle 5, then wait_cnt = 0 and data wins again.
- Byte store: d_we_i = 1, d_be_i = 4'b0100, d_addr_i = 0x2000, d_wdata_i = 0x00AB0000 → mem_we_o = 4'b0100 and mem_en_o = 1; next cycle d_rvalid_o = 1; readback of 0x2000 shows byte 2 = 0xAB.
- AMO lock: data read with d_lock_i = 1 while fetch requests continuously → LOCKED; if_gnt_o stays 0 for 3 idle data cycles, even past MAX_WAIT; data write with d_lock_i = 0 granted → the next cycle if_gnt_o = 1.
- Reset mid-access: assert rst_n_i = 0 in the cycle after a fetch grant → if_rvalid_o = 0 immediately; after release, a both-request tie grants data.
- ARB_ROUND_ROBIN_EN defined, both ports requesting for 6 cycles → grants alternate D, F, D, F, D, F.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch and load/store, with AMO locking.
// Optional ARB_ROUND_ROBIN_EN replaces fixed data priority plus the starvation guard with round-robin ties.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    input  logic              d_lock_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic {ST_ARB, ST_LOCKED} state_e;
    typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_IF = 2'b01, OWN_D = 2'b10} owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic   if_gnt, d_gnt;

`ifdef ARB_ROUND_ROBIN_EN
    // High when the data port took the most recent grant.
    logic last_d_q, last_d_d;
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0] wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_ARB: begin
                if (if_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (last_d_q) if_gnt = 1'b1;
                    else          d_gnt  = 1'b1;
`else
                    if (wait_cnt_q == MAX_WAIT_C) if_gnt = 1'b1;
                    else                          d_gnt  = 1'b1;
`endif
                end else begin
                    if_gnt = if_req_i;
                    d_gnt  = d_req_i;
                end
                if (d_gnt && d_lock_i) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                // Fetch is shut out until the AMO write phase releases the lock.
                d_gnt = d_req_i;
                if (d_gnt && !d_lock_i) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt)     owner_d = OWN_IF;
        else if (d_gnt) owner_d = OWN_D;
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        last_d_d = last_d_q;
        if (if_gnt)     last_d_d = 1'b0;
        else if (d_gnt) last_d_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) last_d_q <= 1'b0;
        else          last_d_q <= last_d_d;
    end
`else
    always_comb begin
        wait_cnt_d = 4'd0;
        if (if_req_i && !if_gnt) begin
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) wait_cnt_q <= 4'd0;
        else          wait_cnt_q <= wait_cnt_d;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_ARB;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign if_gnt_o    = if_gnt;
    assign d_gnt_o     = d_gnt;
    assign mem_en_o    = if_gnt | d_gnt;
    assign mem_addr_o  = if_gnt ? if_addr_i : (d_gnt ? d_addr_i : '0);
    assign mem_we_o    = (d_gnt && d_we_i) ? d_be_i : 4'b0000;
    assign mem_wdata_o = d_gnt ? d_wdata_i : 32'd0;

    assign if_rvalid_o = (owner_q == OWN_IF);
    assign d_rvalid_o  = (owner_q == OWN_D);
    assign if_rdata_o  = (owner_q == OWN_IF) ? mem_rdata_i : 32'd0;
    assign d_rdata_o   = (owner_q == OWN_D)  ? mem_rdata_i : 32'd0;

endmodule
